regfile_operand_stage: RTL and testbench

Operand-fetch stage directly upstream of the 16-bit LEGv8 ALU.
- Holds the 32-entry register file (X31 reads as zero, XZR).
- Reads two source registers, or one register plus an immediate, with same-cycle write-back bypass.
- Registers A, B, FS and C0 into a single-entry pipeline slot with a valid/ready handshake toward the ALU/execute stage.

---
 rtl/regfile_operand_stage.sv | 103 ++++++++++
 tb/tb_regfile_operand_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_operand_stage.sv
// Operand-fetch stage feeding the 16-bit LEGv8 ALU: 32-entry register file with XZR,
// write-back bypass and a single-entry valid/ready output slot. Optional: REGFILE_DEBUG_PORT_EN.
module regfile_operand_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  imm_sel,
  input  logic [4:0]            fs_in,
  input  logic                  c0_in,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [4:0]            FS,
  output logic                  C0
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
`endif
);

  localparam int                  NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [4:0]            fs_q;
  logic                  c0_q;

  logic [DATA_WIDTH-1:0] a_d, b_d;
  logic                  accept;

  // NOTE: the register file is reset entry by entry because a cleared file after reset is
  // architecturally visible; this rules out block-RAM mapping, which is acceptable at 32x16.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_en && (wb_addr != ZERO_IDX)) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples
      // pre-edge values regardless of block ordering.
      regs_q[wb_addr] <= wb_data;
    end
  end

  // XZR wins over the bypass, so a discarded write to X31 never leaks into an operand.
  function automatic logic [DATA_WIDTH-1:0] read_src(input logic [ADDR_WIDTH-1:0] src);
    if (src == ZERO_IDX)               return '0;
    if (wb_en && (wb_addr == src))     return wb_data;
    return regs_q[src];
  endfunction

  always_comb begin
    a_d = read_src(rs1_addr);
    b_d = imm_sel ? imm : read_src(rs2_addr);
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      fs_q        <= '0;
      c0_q        <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      a_q         <= a_d;
      b_q         <= b_d;
      fs_q        <= fs_in;
      c0_q        <= c0_in;
    end else if (out_ready) begin
      // Slot drained with nothing behind it; operands keep their last values.
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign FS        = fs_q;
  assign C0        = c0_q;

`ifdef REGFILE_DEBUG_PORT_EN
  assign dbg_data = (dbg_addr == ZERO_IDX) ? '0 : regs_q[dbg_addr];
`endif

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Scoreboard bench for regfile_operand_stage: the driver pushes the expected operation at its
// accept edge, and a negedge monitor pops and compares whenever the slot is consumed.
module tb_regfile_operand_stage;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  fs;
    logic        c0;
  } op_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [15:0] imm = '0;
  logic        imm_sel = 1'b0;
  logic [4:0]  fs_in = '0;
  logic        c0_in = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] A, B;
  logic [4:0]  FS;
  logic        C0;

  op_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  regfile_operand_stage dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .imm(imm), .imm_sel(imm_sel), .fs_in(fs_in), .c0_in(c0_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .FS(FS), .C0(C0)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one transfer per negedge with valid && ready (inputs only move just after posedge).
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        op_t e;
        e = sb.pop_front();
        check("mon_A",  32'(A),  32'(e.a));
        check("mon_B",  32'(B),  32'(e.b));
        check("mon_FS", 32'(FS), 32'(e.fs));
        check("mon_C0", 32'(C0), 32'(e.c0));
      end
    end
  end

  task automatic write_reg(input logic [4:0] addr, input logic [15:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    @(posedge clock); #1;
    wb_en = 1'b0;
  endtask

  // Presents one op and waits (bounded) for its accept edge; any wb_* set by the caller
  // is applied in the accept cycle and cleared afterwards.
  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic isel,
                       input logic [15:0] im, input logic [4:0] f, input logic c,
                       input op_t exp);
    in_valid = 1'b1; rs1_addr = r1; rs2_addr = r2; imm_sel = isel; imm = im;
    fs_in = f; c0_in = c;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        sb.push_back(exp);
        #1;
        in_valid = 1'b0;
        wb_en    = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
    wb_en    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_A",  32'(A),  32'd0);
    check("rst_B",  32'(B),  32'd0);
    check("rst_FS", 32'(FS), 32'd0);
    check("rst_C0", 32'(C0), 32'd0);
    #14 reset_n = 1'b1;
    @(posedge clock); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Reset then read: cleared registers
    issue(5'd3, 5'd4, 1'b0, 16'h0000, 5'b01000, 1'b0, '{16'h0000, 16'h0000, 5'b01000, 1'b0});
    check("lat1_out_valid", 32'(out_valid), 32'd1);

    // Write then read, plus B from immediate
    write_reg(5'd3, 16'h1234);
    issue(5'd3, 5'd9, 1'b1, 16'h0005, 5'b00010, 1'b1, '{16'h1234, 16'h0005, 5'b00010, 1'b1});

    // Same-cycle bypass with rs1 == rs2
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 16'hBEEF;
    issue(5'd7, 5'd7, 1'b0, 16'h0000, 5'b00101, 1'b0, '{16'hBEEF, 16'hBEEF, 5'b00101, 1'b0});
    // Bypass value must also have landed in the file
    issue(5'd7, 5'd3, 1'b0, 16'h0000, 5'b00001, 1'b0, '{16'hBEEF, 16'h1234, 5'b00001, 1'b0});

    // Zero register: write discarded, immediate path
    write_reg(5'd31, 16'hFFFF);
    issue(5'd31, 5'd0, 1'b1, 16'h0010, 5'b01100, 1'b0, '{16'h0000, 16'h0010, 5'b01100, 1'b0});
    // XZR beats bypass on both ports
    wb_en = 1'b1; wb_addr = 5'd31; wb_data = 16'hFFFF;
    issue(5'd31, 5'd31, 1'b0, 16'h0000, 5'b00011, 1'b1, '{16'h0000, 16'h0000, 5'b00011, 1'b1});

    // Back-to-back full throughput
    write_reg(5'd5, 16'h0055);
    issue(5'd5, 5'd3, 1'b0, 16'h0000, 5'b10000, 1'b0, '{16'h0055, 16'h1234, 5'b10000, 1'b0});
    issue(5'd3, 5'd5, 1'b0, 16'h0000, 5'b10001, 1'b1, '{16'h1234, 16'h0055, 5'b10001, 1'b1});
    check("b2b_out_valid", 32'(out_valid), 32'd1);
    repeat (2) @(posedge clock);
    #1;
    check("drained_out_valid", 32'(out_valid), 32'd0);

    // Back-pressure: hold slot for 3 cycles while X2 is written underneath it
    out_ready = 1'b0;
    issue(5'd2, 5'd0, 1'b1, 16'h0011, 5'b00011, 1'b1, '{16'h0000, 16'h0011, 5'b00011, 1'b1});
    in_valid = 1'b1; rs1_addr = 5'd2; rs2_addr = 5'd0; imm_sel = 1'b0; fs_in = 5'b00100; c0_in = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 16'h00AA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_A",  32'(A),  32'h0000);
      check("stall_B",  32'(B),  32'h0011);
      check("stall_FS", 32'(FS), 32'd3);
      check("stall_C0", 32'(C0), 32'd1);
      @(posedge clock); #1;
      wb_en = 1'b0;
    end
    out_ready = 1'b1;
    issue(5'd2, 5'd0, 1'b0, 16'h0000, 5'b00100, 1'b0, '{16'h00AA, 16'h0000, 5'b00100, 1'b0});
    check("reload_out_valid", 32'(out_valid), 32'd1);
    check("reload_A", 32'(A), 32'h00AA);
    repeat (2) @(posedge clock);
    #1;

    // Async reset mid-stall drops the slot and clears the file
    out_ready = 1'b0;
    issue(5'd3, 5'd0, 1'b1, 16'h0077, 5'b00110, 1'b1, '{16'h1234, 16'h0077, 5'b00110, 1'b1});
    @(negedge clock);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_A", 32'(A), 32'd0);
    check("midrst_B", 32'(B), 32'd0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    issue(5'd3, 5'd2, 1'b0, 16'h0000, 5'b00111, 1'b0, '{16'h0000, 16'h0000, 5'b00111, 1'b0});

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
